// File: rtl/exec_sched_if.sv
// exec_sched_if: handshake bundle between the reservation-station arrays
// and the issue/writeback scheduler. The master side (RS arrays) presents
// ready entries and ROB indices. The slave side (scheduler) returns issue
// pulses, unit busy flags and the CDB broadcast.
interface exec_sched_if #(
  parameter int NRS = 3
);
  logic [2:0]       rob_head;
  logic [NRS-1:0]   add_rdy;
  logic [3*NRS-1:0] add_rob;
  logic [NRS-1:0]   mul_rdy;
  logic [3*NRS-1:0] mul_rob;
  logic [NRS-1:0]   mul_div;
  logic             add_issue_v;
  logic [1:0]       add_issue_idx;
  logic             mul_issue_v;
  logic [1:0]       mul_issue_idx;
  logic             add_busy;
  logic             mul_busy;
  logic             cdb_v;
  logic             cdb_src;
  logic [1:0]       cdb_idx;
  logic [2:0]       cdb_rob;

  modport master (
    output rob_head, add_rdy, add_rob, mul_rdy, mul_rob, mul_div,
    input  add_issue_v, add_issue_idx, mul_issue_v, mul_issue_idx,
    input  add_busy, mul_busy, cdb_v, cdb_src, cdb_idx, cdb_rob
  );

  modport slave (
    input  rob_head, add_rdy, add_rob, mul_rdy, mul_rob, mul_div,
    output add_issue_v, add_issue_idx, mul_issue_v, mul_issue_idx,
    output add_busy, mul_busy, cdb_v, cdb_src, cdb_idx, cdb_rob
  );
endinterface

// File: rtl/exec_sched.sv
// exec_sched: issue and writeback scheduler for the add/sub and mul/div
// execution units. Each idle unit issues its oldest ready RS entry, times it
// with a latency counter, then competes for the single CDB.
// Optional feature: define CDB_AGE_ARB_EN to arbitrate a CDB collision by
// ROB age; otherwise the mul unit always wins a collision.
module exec_sched #(
  parameter int NRS     = 3,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        flush,
  exec_sched_if.slave bus
);

  localparam int MAXL = (DIV_LAT > MUL_LAT) ? ((DIV_LAT > ADD_LAT) ? DIV_LAT : ADD_LAT)
                                            : ((MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT);
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam logic [CW-1:0] ADD_LD  = CW'(ADD_LAT - 1);
  localparam logic [CW-1:0] MUL_LD  = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CNT_Z   = CW'(32'd0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} st_t;

  // Wrap-around age of a ROB index relative to the head; smaller is older.
  function automatic logic [2:0] age(input logic [2:0] r, input logic [2:0] h);
    return r - h;
  endfunction

  // Oldest ready entry: returns {found, idx[1:0], rob[2:0]}.
  function automatic logic [5:0] pick(input logic [NRS-1:0] rdy,
                                      input logic [3*NRS-1:0] robs,
                                      input logic [2:0] h);
    logic       found;
    logic [1:0] idx;
    logic [2:0] rob;
    logic [2:0] best;
    logic [2:0] a;
    found = 1'b0;
    idx   = 2'd0;
    rob   = 3'd0;
    best  = 3'd7;
    for (int i = 0; i < NRS; i++) begin
      a = age(robs[3*i +: 3], h);
      if (rdy[i] && (!found || (a < best))) begin
        found = 1'b1;
        idx   = i[1:0];
        rob   = robs[3*i +: 3];
        best  = a;
      end else begin
        found = found;
      end
    end
    return {found, idx, rob};
  endfunction

  st_t           add_st_r, add_st_n, mul_st_r, mul_st_n;
  logic [CW-1:0] add_cnt_r, add_cnt_n, mul_cnt_r, mul_cnt_n;
  logic          add_iss_r, add_iss_n, mul_iss_r, mul_iss_n;
  logic [1:0]    add_idx_r, add_idx_n, mul_idx_r, mul_idx_n;
  logic [2:0]    add_rob_r, add_rob_n, mul_rob_r, mul_rob_n;
  logic          add_busy_r, mul_busy_r;
  logic          cdb_v_r, cdb_v_n, cdb_src_r, cdb_src_n;
  logic [1:0]    cdb_idx_r, cdb_idx_n;
  logic [2:0]    cdb_rob_r, cdb_rob_n;

  logic [5:0]    add_pick_s, mul_pick_s;
  logic          add_wins_s, grant_add_s, grant_mul_s;
  logic [CW-1:0] mul_ld_s;

  assign add_pick_s = pick(bus.add_rdy, bus.add_rob, bus.rob_head);
  assign mul_pick_s = pick(bus.mul_rdy, bus.mul_rob, bus.rob_head);
  assign mul_ld_s   = bus.mul_div[mul_pick_s[4:3]] ? DIV_LD : MUL_LD;

`ifdef CDB_AGE_ARB_EN
  assign add_wins_s = age(add_rob_r, bus.rob_head) < age(mul_rob_r, bus.rob_head);
`else
  assign add_wins_s = 1'b0;
`endif

  assign grant_add_s = (add_st_r == DONE) && ((mul_st_r != DONE) || add_wins_s);
  assign grant_mul_s = (mul_st_r == DONE) && ((add_st_r != DONE) || !add_wins_s);

  // Add unit next state: flush kill, issue when idle or granted, countdown, CDB wait.
  always_comb begin
    add_st_n  = add_st_r;
    add_cnt_n = add_cnt_r;
    add_iss_n = 1'b0;
    add_idx_n = add_idx_r;
    add_rob_n = add_rob_r;
    if (flush) begin
      add_st_n  = IDLE;
      add_cnt_n = CNT_Z;
    end else if (((add_st_r == IDLE) || grant_add_s) && add_pick_s[5]) begin
      add_st_n  = BUSY;
      add_cnt_n = ADD_LD;
      add_iss_n = 1'b1;
      add_idx_n = add_pick_s[4:3];
      add_rob_n = add_pick_s[2:0];
    end else begin
      case (add_st_r)
        IDLE:    add_st_n = IDLE;
        BUSY:    if (add_cnt_r == CNT_Z) add_st_n = DONE; else add_cnt_n = add_cnt_r - CNT_ONE;
        DONE:    if (grant_add_s) add_st_n = IDLE; else add_st_n = DONE;
        default: add_st_n = IDLE;
      endcase
    end
  end

  // Mul unit next state: same as add, with divide-dependent latency load.
  always_comb begin
    mul_st_n  = mul_st_r;
    mul_cnt_n = mul_cnt_r;
    mul_iss_n = 1'b0;
    mul_idx_n = mul_idx_r;
    mul_rob_n = mul_rob_r;
    if (flush) begin
      mul_st_n  = IDLE;
      mul_cnt_n = CNT_Z;
    end else if (((mul_st_r == IDLE) || grant_mul_s) && mul_pick_s[5]) begin
      mul_st_n  = BUSY;
      mul_cnt_n = mul_ld_s;
      mul_iss_n = 1'b1;
      mul_idx_n = mul_pick_s[4:3];
      mul_rob_n = mul_pick_s[2:0];
    end else begin
      case (mul_st_r)
        IDLE:    mul_st_n = IDLE;
        BUSY:    if (mul_cnt_r == CNT_Z) mul_st_n = DONE; else mul_cnt_n = mul_cnt_r - CNT_ONE;
        DONE:    if (grant_mul_s) mul_st_n = IDLE; else mul_st_n = DONE;
        default: mul_st_n = IDLE;
      endcase
    end
  end

  // CDB broadcast for the granted unit; suppressed on flush.
  always_comb begin
    cdb_v_n   = 1'b0;
    cdb_src_n = 1'b0;
    cdb_idx_n = 2'd0;
    cdb_rob_n = 3'd0;
    if (!flush && grant_mul_s) begin
      cdb_v_n   = 1'b1;
      cdb_src_n = 1'b1;
      cdb_idx_n = mul_idx_r;
      cdb_rob_n = mul_rob_r;
    end else if (!flush && grant_add_s) begin
      cdb_v_n   = 1'b1;
      cdb_idx_n = add_idx_r;
      cdb_rob_n = add_rob_r;
    end else begin
      cdb_v_n   = 1'b0;
    end
  end

  // State, counters, stored entry info and all registered outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      add_st_r   <= IDLE;
      mul_st_r   <= IDLE;
      add_cnt_r  <= CNT_Z;
      mul_cnt_r  <= CNT_Z;
      add_iss_r  <= 1'b0;
      mul_iss_r  <= 1'b0;
      add_idx_r  <= 2'd0;
      mul_idx_r  <= 2'd0;
      add_rob_r  <= 3'd0;
      mul_rob_r  <= 3'd0;
      add_busy_r <= 1'b0;
      mul_busy_r <= 1'b0;
      cdb_v_r    <= 1'b0;
      cdb_src_r  <= 1'b0;
      cdb_idx_r  <= 2'd0;
      cdb_rob_r  <= 3'd0;
    end else begin
      add_st_r   <= add_st_n;
      mul_st_r   <= mul_st_n;
      add_cnt_r  <= add_cnt_n;
      mul_cnt_r  <= mul_cnt_n;
      add_iss_r  <= add_iss_n;
      mul_iss_r  <= mul_iss_n;
      add_idx_r  <= add_idx_n;
      mul_idx_r  <= mul_idx_n;
      add_rob_r  <= add_rob_n;
      mul_rob_r  <= mul_rob_n;
      add_busy_r <= (add_st_n != IDLE);
      mul_busy_r <= (mul_st_n != IDLE);
      cdb_v_r    <= cdb_v_n;
      cdb_src_r  <= cdb_src_n;
      cdb_idx_r  <= cdb_idx_n;
      cdb_rob_r  <= cdb_rob_n;
    end
  end

  assign bus.add_issue_v   = add_iss_r;
  assign bus.add_issue_idx = add_idx_r;
  assign bus.mul_issue_v   = mul_iss_r;
  assign bus.mul_issue_idx = mul_idx_r;
  assign bus.add_busy      = add_busy_r;
  assign bus.mul_busy      = mul_busy_r;
  assign bus.cdb_v         = cdb_v_r;
  assign bus.cdb_src       = cdb_src_r;
  assign bus.cdb_idx       = cdb_idx_r;
  assign bus.cdb_rob       = cdb_rob_r;

endmodule

// File: tb/tb_exec_sched.sv
// tb_exec_sched: directed vectors with hand-computed expectations for
// exec_sched (default parameters).
module tb_exec_sched;
  logic clk1 = 1'b0;
  logic rst_n;
  logic flush;
  int   n_vec = 0;
  int   n_err = 0;

  exec_sched_if #(.NRS(3)) bus ();

  exec_sched #(.NRS(3), .ADD_LAT(1), .MUL_LAT(3), .DIV_LAT(6)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_add_iss"}, {7'd0, bus.add_issue_v}, 8'd0);
    check_eq({tag, "_mul_iss"}, {7'd0, bus.mul_issue_v}, 8'd0);
    check_eq({tag, "_cdb_v"},   {7'd0, bus.cdb_v}, 8'd0);
  endtask

  task automatic check_cdb(input string tag, input logic src, input logic [1:0] idx, input logic [2:0] rob);
    check_eq({tag, "_v"},   {7'd0, bus.cdb_v}, 8'd1);
    check_eq({tag, "_src"}, {7'd0, bus.cdb_src}, {7'd0, src});
    check_eq({tag, "_idx"}, {6'd0, bus.cdb_idx}, {6'd0, idx});
    check_eq({tag, "_rob"}, {5'd0, bus.cdb_rob}, {5'd0, rob});
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.rob_head = 3'd0;
    bus.add_rdy  = 3'b000;
    bus.add_rob  = 9'd0;
    bus.mul_rdy  = 3'b000;
    bus.mul_rob  = 9'd0;
    bus.mul_div  = 3'b000;
    #3;
    check_quiet("rst");
    check_eq("rst_add_busy", {7'd0, bus.add_busy}, 8'd0);
    check_eq("rst_mul_busy", {7'd0, bus.mul_busy}, 8'd0);
    @(negedge clk1);
    rst_n = 1'b1;

    // Basic add issue: entry1 rob 5
    bus.add_rdy = 3'b010;
    bus.add_rob = {3'd0, 3'd5, 3'd0};
    tick();  // E0
    check_eq("t1_iss_v", {7'd0, bus.add_issue_v}, 8'd1);
    check_eq("t1_iss_idx", {6'd0, bus.add_issue_idx}, 8'd1);
    check_eq("t1_busy", {7'd0, bus.add_busy}, 8'd1);
    bus.add_rdy = 3'b000;
    tick();  // E1
    check_quiet("t1_e1");
    tick();  // E2
    check_cdb("t1_cdb", 1'b0, 2'd1, 3'd5);
    check_eq("t1_e2_iss", {7'd0, bus.add_issue_v}, 8'd0);
    check_eq("t1_e2_busy", {7'd0, bus.add_busy}, 8'd0);
    tick();  // E3
    check_quiet("t1_e3");

    // Oldest-first: head 1, robs {6,2,4} -> idx1, then {6,4} -> idx2
    bus.rob_head = 3'd1;
    bus.add_rdy  = 3'b111;
    bus.add_rob  = {3'd4, 3'd2, 3'd6};
    tick();  // E0
    check_eq("t2_iss_v", {7'd0, bus.add_issue_v}, 8'd1);
    check_eq("t2_iss_idx", {6'd0, bus.add_issue_idx}, 8'd1);
    bus.add_rdy = 3'b101;
    tick();  // E1: not eligible while busy
    check_quiet("t2_e1");
    tick();  // E2: CDB for rob 2 and back-to-back issue of idx2
    check_cdb("t2_cdb1", 1'b0, 2'd1, 3'd2);
    check_eq("t2_b2b_v", {7'd0, bus.add_issue_v}, 8'd1);
    check_eq("t2_b2b_idx", {6'd0, bus.add_issue_idx}, 8'd2);
    bus.add_rdy = 3'b000;
    tick();  // E3
    check_eq("t2_e3_cdb", {7'd0, bus.cdb_v}, 8'd0);
    tick();  // E4
    check_cdb("t2_cdb2", 1'b0, 2'd2, 3'd4);
    tick();
    check_eq("t2_idle", {7'd0, bus.add_busy}, 8'd0);

    // Wrap-around age: head 6, mul robs {1,7} -> idx1
    bus.rob_head = 3'd6;
    bus.mul_rdy  = 3'b011;
    bus.mul_rob  = {3'd0, 3'd7, 3'd1};
    bus.mul_div  = 3'b000;
    tick();  // E0
    check_eq("t3_iss_v", {7'd0, bus.mul_issue_v}, 8'd1);
    check_eq("t3_iss_idx", {6'd0, bus.mul_issue_idx}, 8'd1);
    bus.mul_rdy = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("t3_wait_cdb", {7'd0, bus.cdb_v}, 8'd0);
    end
    tick();  // E4
    check_cdb("t3_cdb", 1'b1, 2'd1, 3'd7);
    tick();
    check_eq("t3_idle", {7'd0, bus.mul_busy}, 8'd0);

    // Divide latency and CDB collision: div rob 3 at E0, add rob 2 at E5
    bus.rob_head = 3'd0;
    bus.mul_rdy  = 3'b001;
    bus.mul_rob  = {3'd0, 3'd0, 3'd3};
    bus.mul_div  = 3'b001;
    tick();  // E0
    check_eq("t4_div_iss", {7'd0, bus.mul_issue_v}, 8'd1);
    bus.mul_rdy = 3'b000;
    bus.mul_div = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("t4_div_wait", {7'd0, bus.cdb_v}, 8'd0);
    end
    bus.add_rdy = 3'b001;
    bus.add_rob = {3'd0, 3'd0, 3'd2};
    tick();  // E5
    check_eq("t4_add_iss", {7'd0, bus.add_issue_v}, 8'd1);
    bus.add_rdy = 3'b000;
    tick();  // E6
    check_eq("t4_e6_cdb", {7'd0, bus.cdb_v}, 8'd0);
    check_eq("t4_e6_mbusy", {7'd0, bus.mul_busy}, 8'd1);
    tick();  // E7
`ifdef CDB_AGE_ARB_EN
    check_cdb("t4_first", 1'b0, 2'd0, 3'd2);
    tick();  // E8
    check_cdb("t4_second", 1'b1, 2'd0, 3'd3);
`else
    check_cdb("t4_first", 1'b1, 2'd0, 3'd3);
    tick();  // E8
    check_cdb("t4_second", 1'b0, 2'd0, 3'd2);
`endif
    tick();  // E9
    check_quiet("t4_e9");
    check_eq("t4_abusy", {7'd0, bus.add_busy}, 8'd0);
    check_eq("t4_mbusy", {7'd0, bus.mul_busy}, 8'd0);

    // Flush while mul BUSY: op discarded, no issue on flush edge, issue after
    bus.mul_rdy = 3'b100;
    bus.mul_rob = {3'd4, 3'd0, 3'd0};
    tick();  // E0
    check_eq("t5_iss_idx", {6'd0, bus.mul_issue_idx}, 8'd2);
    bus.mul_rdy = 3'b001;
    bus.mul_rob = {3'd0, 3'd0, 3'd5};
    tick();  // E1
    check_eq("t5_e1_iss", {7'd0, bus.mul_issue_v}, 8'd0);
    flush = 1'b1;
    tick();  // E2 flush edge
    flush = 1'b0;
    check_quiet("t5_flush");
    check_eq("t5_flush_busy", {7'd0, bus.mul_busy}, 8'd0);
    tick();  // E3
    check_eq("t5_re_iss_v", {7'd0, bus.mul_issue_v}, 8'd1);
    check_eq("t5_re_iss_idx", {6'd0, bus.mul_issue_idx}, 8'd0);
    bus.mul_rdy = 3'b000;
    for (int k = 4; k <= 6; k++) begin
      tick();
      check_eq("t5_no_stale_cdb", {7'd0, bus.cdb_v}, 8'd0);
    end
    tick();  // E7
    check_cdb("t5_cdb", 1'b1, 2'd0, 3'd5);
    tick();
    check_eq("t5_end_cdb", {7'd0, bus.cdb_v}, 8'd0);

    // Async reset while add is DONE
    bus.add_rdy = 3'b010;
    bus.add_rob = {3'd0, 3'd6, 3'd0};
    tick();  // E0
    check_eq("t6_iss_v", {7'd0, bus.add_issue_v}, 8'd1);
    bus.add_rdy = 3'b000;
    tick();  // E1: DONE
    check_eq("t6_done_busy", {7'd0, bus.add_busy}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("t6_rst");
    check_eq("t6_rst_busy", {7'd0, bus.add_busy}, 8'd0);
    check_eq("t6_rst_idx", {6'd0, bus.add_issue_idx}, 8'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t6_no_cdb", {7'd0, bus.cdb_v}, 8'd0);
      check_eq("t6_idle", {7'd0, bus.add_busy}, 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
